// File: rtl/reg_map_arbiter.sv
// Two-requester round-robin arbiter driving a single AXI4-Lite master port
// towards the simple_reg_map slave; one transaction in flight at a time.
module reg_map_arbiter #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_LIMIT = 'h10
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0]                   req_we,
    input  logic [2*ADDR_WIDTH-1:0]      req_addr,
    input  logic [2*DATA_WIDTH-1:0]      req_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0]  req_wstrb,
    output logic [1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic [ADDR_WIDTH-1:0]        M_AXI_AWADDR,
    output logic [2:0]                   M_AXI_AWPROT,
    output logic                         M_AXI_AWVALID,
    input  logic                         M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]        M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
    output logic                         M_AXI_WVALID,
    input  logic                         M_AXI_WREADY,
    input  logic [1:0]                   M_AXI_BRESP,
    input  logic                         M_AXI_BVALID,
    output logic                         M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]        M_AXI_ARADDR,
    output logic [2:0]                   M_AXI_ARPROT,
    output logic                         M_AXI_ARVALID,
    input  logic                         M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]        M_AXI_RDATA,
    input  logic [1:0]                   M_AXI_RRESP,
    input  logic                         M_AXI_RVALID,
    output logic                         M_AXI_RREADY
);
    localparam int unsigned SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, ERR} state_t;

    state_t                state;
    logic                  last;
    logic                  gnt;
    logic                  aw_done;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] axi_addr;

    logic                  gnt_any;
    logic                  gnt_idx;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [SW-1:0]         sel_wstrb;
    logic                  sel_bad;
    logic                  aw_hs;
    logic                  w_hs;

    // Grant is decided combinationally in IDLE so the requester sees req_ready
    // in the same cycle its command is captured; held off during the rsp pulse.
    always_comb begin
        gnt_any   = (state == IDLE) && (rsp_valid == '0) && (req_valid != '0);
        gnt_idx   = (req_valid == 2'b11) ? ~last : req_valid[1];
        sel_we    = gnt_idx ? req_we[1] : req_we[0];
        sel_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        sel_wdata = gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        sel_wstrb = gnt_idx ? req_wstrb[2*SW-1:SW] : req_wstrb[SW-1:0];
        sel_bad   = 32'(sel_addr) >= ADDR_LIMIT;
        req_ready = 2'b00;
        if (gnt_any && ARESETN)
            req_ready = gnt_idx ? 2'b10 : 2'b01;
        aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
        w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    end

    assign M_AXI_AWADDR = axi_addr;
    assign M_AXI_ARADDR = axi_addr;
    assign M_AXI_AWPROT = '0;
    assign M_AXI_ARPROT = '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            last          <= 1'b1;
            gnt           <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            axi_addr      <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gnt         <= gnt_idx;
                        last        <= gnt_idx;
                        axi_addr    <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        M_AXI_WDATA <= sel_wdata;
                        M_AXI_WSTRB <= sel_wstrb;
                        if (sel_bad) begin
                            state              <= ERR;
                            rsp_valid[gnt_idx] <= 1'b1;
                            rsp_resp           <= 2'b10;
                            rsp_rdata          <= '0;
                        end else if (sel_we) begin
                            state         <= WRITE;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= READ;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (aw_hs) M_AXI_AWVALID <= 1'b0;
                    if (w_hs)  M_AXI_WVALID  <= 1'b0;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state        <= WRESP;
                        M_AXI_BREADY <= 1'b1;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || w_hs;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        state          <= IDLE;
                        M_AXI_BREADY   <= 1'b0;
                        rsp_valid[gnt] <= 1'b1;
                        rsp_resp       <= M_AXI_BRESP;
                        rsp_rdata      <= '0;
                    end
                end
                READ: begin
                    if (M_AXI_ARREADY) begin
                        state         <= RRESP;
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                RRESP: begin
                    if (M_AXI_RVALID) begin
                        state          <= IDLE;
                        M_AXI_RREADY   <= 1'b0;
                        rsp_valid[gnt] <= 1'b1;
                        rsp_resp       <= M_AXI_RRESP;
                        rsp_rdata      <= M_AXI_RDATA;
                    end
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_map_arbiter.sv
// Directed bench for reg_map_arbiter with a small AXI4-Lite register slave model.
module tb_reg_map_arbiter;
    localparam int AW = 5;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    always #5 ACLK = ~ACLK;

    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0]      req_we = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [63:0]     req_wdata = '0;
    logic [7:0]      req_wstrb = '0;
    logic [1:0]      rsp_valid;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0]     M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]      M_AXI_WSTRB;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;

    reg_map_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .ADDR_LIMIT('h10)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave model: AW/AR always ready, WREADY held low for stall_req cycles.
    logic [31:0]   mem [4];
    logic          s_bvalid = 1'b0, s_rvalid = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0]   s_rdata = '0, w_d = '0;
    logic [AW-1:0] aw_a = '0;
    logic [1:0]    widx;
    logic          aw_hs, w_hs;
    int            w_wait = 0;
    int            stall_req = 0;

    assign M_AXI_AWREADY = 1'b1;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_WREADY  = (w_wait >= stall_req);
    assign M_AXI_BRESP   = 2'b00;
    assign M_AXI_BVALID  = s_bvalid;
    assign M_AXI_RDATA   = s_rdata;
    assign M_AXI_RRESP   = 2'b00;
    assign M_AXI_RVALID  = s_rvalid;
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign widx  = aw_hs ? M_AXI_AWADDR[3:2] : aw_a[3:2];

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            w_wait <= 0; s_rdata <= '0; aw_a <= '0; w_d <= '0;
        end else begin
            if (w_hs) w_wait <= 0;
            else if (M_AXI_WVALID) w_wait <= w_wait + 1;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                mem[widx] <= w_hs ? M_AXI_WDATA : w_d;
                s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
                if (w_hs)  begin w_got <= 1'b1;  w_d <= M_AXI_WDATA; end
            end
            if (s_bvalid && M_AXI_BREADY) s_bvalid <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                s_rvalid <= 1'b1; s_rdata <= mem[M_AXI_ARADDR[3:2]];
            end else if (s_rvalid && M_AXI_RREADY) s_rvalid <= 1'b0;
        end
    end

    int cyc = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, wstall_cnt = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
        if (M_AXI_WVALID) w_cnt <= w_cnt + 1;
        if (M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;
        if (M_AXI_WVALID && !M_AXI_WREADY) wstall_cnt <= wstall_cnt + 1;
        if (rsp_valid[0]) rsp_cnt0 <= rsp_cnt0 + 1;
        if (rsp_valid[1]) rsp_cnt1 <= rsp_cnt1 + 1;
    end

    int          checks = 0, errors = 0;
    int          g_cyc [2];
    int          r_cyc [2];
    logic [31:0] r_data [2];
    logic [1:0]  r_resp [2];

    // Drives the masked requesters, drops each valid after its grant and
    // records grant/response cycles; entered and left at 1 time unit after an edge.
    task automatic run(input logic [1:0] mask, input logic [1:0] we,
                       input logic [2*AW-1:0] addr, input logic [63:0] wdata);
        logic [1:0] pend;
        logic [1:0] drop;
        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = '1;
        req_valid = mask; pend = mask; drop = '0;
        for (int i = 0; i < 2; i++) begin g_cyc[i] = -1; r_cyc[i] = -1; end
        for (int n = 0; n < 100 && pend != '0; n++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i] && g_cyc[i] < 0) begin g_cyc[i] = cyc; drop[i] = 1'b1; end
                if (rsp_valid[i] && pend[i]) begin
                    r_cyc[i] = cyc; r_data[i] = rsp_rdata; r_resp[i] = rsp_resp; pend[i] = 1'b0;
                end
            end
            @(posedge ACLK); #1;
            req_valid = req_valid & ~drop;
        end
        req_valid = '0;
        if (pend != '0) begin
            checks++; errors++;
            $display("FAIL run_timeout: pending=%b, expected 00", pend);
        end
    endtask

    task automatic apply_reset;
        req_valid = '0;
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_reset;
        #1 ARESETN = 1'b0;
        req_valid = 2'b11; req_we = 2'b11; req_addr = '0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({req_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
             M_AXI_ARVALID, M_AXI_RREADY} !== 9'd0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b, expected 0", {req_ready, rsp_valid,
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        checks++;
        if ({rsp_rdata, rsp_resp, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h resp=%b awaddr=%h wdata=%h, expected 0",
                     rsp_rdata, rsp_resp, M_AXI_AWADDR, M_AXI_WDATA);
        end
        req_valid = '0;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_basic;
        int c0, c1;
        c0 = rsp_cnt0; c1 = rsp_cnt1;
        for (int i = 0; i < 4; i++) begin
            run(2'b01, 2'b01, {AW'(0), AW'(i * 4)}, {32'h0, 32'(i + 1)});
            checks++;
            if (r_resp[0] !== 2'b00 || r_cyc[0] - g_cyc[0] != 3) begin
                errors++;
                $display("FAIL basic_write%0d: resp=%b lat=%0d, expected 00 lat=3",
                         i, r_resp[0], r_cyc[0] - g_cyc[0]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            run(2'b01, 2'b00, {AW'(0), AW'(i * 4)}, 64'h0);
            checks++;
            if (r_data[0] !== 32'(i + 1) || r_resp[0] !== 2'b00 || r_cyc[0] - g_cyc[0] != 3) begin
                errors++;
                $display("FAIL basic_read%0d: data=%h resp=%b lat=%0d, expected %h 00 lat=3",
                         i, r_data[0], r_resp[0], r_cyc[0] - g_cyc[0], i + 1);
            end
        end
        checks++;
        if (rsp_cnt0 - c0 != 8 || rsp_cnt1 != c1) begin
            errors++;
            $display("FAIL basic_rsp_count: rsp0=%0d rsp1=%0d, expected 8 0", rsp_cnt0 - c0, rsp_cnt1 - c1);
        end
    endtask

    task automatic test_arbitration;
        apply_reset();
        run(2'b11, 2'b01, {AW'(4), AW'(4)}, {32'h0, 32'hA5});
        checks++;
        if (g_cyc[1] - g_cyc[0] != 4) begin
            errors++;
            $display("FAIL arb_first_order: g0=%0d g1=%0d, expected g1=g0+4", g_cyc[0], g_cyc[1]);
        end
        checks++;
        if (r_data[1] !== 32'hA5 || r_resp[1] !== 2'b00 || r_resp[0] !== 2'b00) begin
            errors++;
            $display("FAIL arb_first_data: data=%h resp1=%b resp0=%b, expected a5 00 00",
                     r_data[1], r_resp[1], r_resp[0]);
        end
        // A lone req0 grant leaves req0 as last winner, so the contested repeat goes to req1.
        run(2'b01, 2'b01, {AW'(0), AW'(4)}, {32'h0, 32'h5A});
        run(2'b11, 2'b01, {AW'(4), AW'(4)}, {32'h0, 32'h3C});
        checks++;
        if (g_cyc[0] - g_cyc[1] != 4) begin
            errors++;
            $display("FAIL arb_repeat_order: g0=%0d g1=%0d, expected g0=g1+4", g_cyc[0], g_cyc[1]);
        end
        checks++;
        if (r_data[1] !== 32'h5A) begin
            errors++;
            $display("FAIL arb_repeat_data: got %h, expected 5a", r_data[1]);
        end
        run(2'b10, 2'b00, {AW'(4), AW'(0)}, 64'h0);
        checks++;
        if (r_data[1] !== 32'h3C) begin
            errors++;
            $display("FAIL arb_repeat_write: got %h, expected 3c", r_data[1]);
        end
    endtask

    task automatic test_error;
        int a0, w0, ar0;
        a0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
        run(2'b10, 2'b00, {AW'(5'h10), AW'(0)}, 64'h0);
        checks++;
        if (r_cyc[1] - g_cyc[1] != 1 || r_resp[1] !== 2'b10 || r_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL err_read: lat=%0d resp=%b data=%h, expected 1 10 0",
                     r_cyc[1] - g_cyc[1], r_resp[1], r_data[1]);
        end
        run(2'b01, 2'b01, {AW'(0), AW'(5'h1F)}, {32'h0, 32'hFFFF});
        checks++;
        if (r_cyc[0] - g_cyc[0] != 1 || r_resp[0] !== 2'b10 || r_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL err_write: lat=%0d resp=%b data=%h, expected 1 10 0",
                     r_cyc[0] - g_cyc[0], r_resp[0], r_data[0]);
        end
        checks++;
        if (aw_cnt != a0 || w_cnt != w0 || ar_cnt != ar0) begin
            errors++;
            $display("FAIL err_no_axi: aw=%0d w=%0d ar=%0d, expected 0 0 0",
                     aw_cnt - a0, w_cnt - w0, ar_cnt - ar0);
        end
    endtask

    task automatic test_wready_stall;
        int a0, s0, c0;
        a0 = aw_cnt; s0 = wstall_cnt; c0 = rsp_cnt0;
        stall_req = 5;
        run(2'b01, 2'b01, {AW'(0), AW'(5'hC)}, {32'h0, 32'h1234_5678});
        stall_req = 0;
        checks++;
        if (aw_cnt - a0 != 1 || wstall_cnt - s0 != 5) begin
            errors++;
            $display("FAIL stall_valids: aw_cycles=%0d w_stall=%0d, expected 1 5", aw_cnt - a0, wstall_cnt - s0);
        end
        checks++;
        if (rsp_cnt0 - c0 != 1 || r_cyc[0] - g_cyc[0] != 8) begin
            errors++;
            $display("FAIL stall_rsp: count=%0d lat=%0d, expected 1 8", rsp_cnt0 - c0, r_cyc[0] - g_cyc[0]);
        end
        run(2'b01, 2'b00, {AW'(0), AW'(5'hC)}, 64'h0);
        checks++;
        if (r_data[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL stall_data: got %h, expected 12345678", r_data[0]);
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        req_we = 2'b01; req_addr = {AW'(0), AW'(4)}; req_wdata = {32'h0, 32'hDEAD_BEEF};
        req_wstrb = '1; req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mid_grant: got %b, expected 01", req_ready);
        end
        @(posedge ACLK); #1;
        req_valid = '0;
        @(posedge ACLK); #1;
        checks++;
        if (M_AXI_BREADY !== 1'b1) begin
            errors++;
            $display("FAIL mid_wresp: bready=%b, expected 1", M_AXI_BREADY);
        end
        c0 = rsp_cnt0;
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
             M_AXI_ARVALID, M_AXI_RREADY} !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b, expected 0", {req_ready, rsp_valid,
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if (rsp_cnt0 != c0) begin
            errors++;
            $display("FAIL mid_no_rsp: got %0d pulses, expected 0", rsp_cnt0 - c0);
        end
        run(2'b01, 2'b01, {AW'(0), AW'(8)}, {32'h0, 32'h7});
        checks++;
        if (r_resp[0] !== 2'b00 || r_cyc[0] - g_cyc[0] != 3) begin
            errors++;
            $display("FAIL mid_after_write: resp=%b lat=%0d, expected 00 3", r_resp[0], r_cyc[0] - g_cyc[0]);
        end
        run(2'b01, 2'b00, {AW'(0), AW'(8)}, 64'h0);
        checks++;
        if (r_data[0] !== 32'h7) begin
            errors++;
            $display("FAIL mid_after_read: got %h, expected 7", r_data[0]);
        end
    endtask

    task automatic test_back_to_back;
        int g1, r1;
        run(2'b01, 2'b01, {AW'(0), AW'(0)}, {32'h0, 32'h11});
        g1 = g_cyc[0]; r1 = r_cyc[0];
        run(2'b01, 2'b01, {AW'(0), AW'(4)}, {32'h0, 32'h22});
        checks++;
        if (r1 - g1 != 3 || r_cyc[0] - g_cyc[0] != 3) begin
            errors++;
            $display("FAIL b2b_latency: first=%0d second=%0d, expected 3 3", r1 - g1, r_cyc[0] - g_cyc[0]);
        end
        checks++;
        if (g_cyc[0] - r1 != 1) begin
            errors++;
            $display("FAIL b2b_regrant: gap=%0d, expected 1", g_cyc[0] - r1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_error();
        test_wready_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_map_arbiter.md
Name: reg_map_arbiter

Overview:
- Two-requester arbiter and AXI4-Lite master sequencer for the simple_reg_map register slave (4 x 32-bit registers, byte addresses 0x0-0xC).
- Each requester issues single read/write commands on a valid/ready port. The block grants round-robin and runs exactly one AXI4-Lite transaction at a time.
- It returns the response to the granted requester, so a local sequencer and a host agent can share one register map.

Parameters:
- ADDR_WIDTH, 4, AXI byte-address width
- DATA_WIDTH, 32, AXI data width (fixed 32 in this revision)
- ADDR_LIMIT, 'h10, first illegal byte address; addresses >= ADDR_LIMIT are rejected locally

Ports:
- ACLK  in  1  single clock; all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester command valid
- req_ready  out  2  one-cycle pulse when the command is accepted (granted)
- req_we  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  byte address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  write data
- req_wstrb  in  2*(DATA_WIDTH/8)  write strobes
- rsp_valid  out  2  one-cycle response pulse to the granted requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_resp  out  2  AXI response code, valid with rsp_valid
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_WIDTH/3/1  write address channel
- M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WVALID  out  DATA_WIDTH/4/1  write data channel
- M_AXI_WREADY  in  1
- M_AXI_BRESP/BVALID  in  2/1; M_AXI_BREADY  out  1
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_WIDTH/3/1  read address channel
- M_AXI_ARREADY  in  1
- M_AXI_RDATA/RRESP/RVALID  in  DATA_WIDTH/2/1; M_AXI_RREADY  out  1

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All outputs 0, including every AXI valid/ready and req_ready/rsp_valid.
  - FSM -> IDLE; round-robin pointer set so requester 0 has priority.
  - Reset mid-transaction abandons the transaction with no response; requesters reissue.
- FSM states: IDLE, WRITE, WRESP, READ, RRESP, ERR.
- IDLE:
  - If any req_valid is set, grant one. If both are set, grant the requester not granted last.
  - In the grant cycle: pulse req_ready[g], capture we/addr/wdata/wstrb; low 2 address bits forced to 0 on the AXI side.
  - Next state: ERR if addr >= ADDR_LIMIT; else WRITE if we=1; else READ.
- WRITE:
  - AWVALID and WVALID both assert on entry; AWPROT = 0.
  - Each valid drops independently after its own handshake (aw_done/w_done flags). Same-cycle handshakes are allowed.
  - When both are done, go to WRESP.
- WRESP: BREADY=1. On BVALID, latch BRESP, pulse rsp_valid[g] the next cycle (rsp_rdata = 0), then go to IDLE.
- READ: ARVALID=1, ARPROT=0. On ARREADY, drop ARVALID and go to RRESP.
- RRESP: RREADY=1. On RVALID, latch RDATA/RRESP, pulse rsp_valid[g] the next cycle, then go to IDLE.
- ERR: no AXI traffic. Pulse rsp_valid[g] with rsp_resp = 2'b10 (SLVERR) and rsp_rdata = 0 the cycle after the grant, then go to IDLE.
- A new grant is allowed in the cycle after the rsp_valid pulse; at most one outstanding transaction.
- Minimum latency with an always-ready slave, grant at cycle 0:
  - AW/W handshake at cycle 1; B at cycle 2 at the earliest; rsp_valid at cycle 3.
  - Reads follow the same timing.
- Requester rules:
  - Hold command fields stable while req_valid=1 and req_ready=0.
  - Withdrawing req_valid before the grant is legal.
  - Changes after the grant are ignored.
- Slave stalls: AXI valids are held indefinitely until ready; there is no timeout.
- The round-robin pointer updates only on a grant. A lone requester is granted back-to-back.

Test Plan:
- Req0 writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then reads back -> 4 rsp_valid[0] pulses per phase, rsp_rdata = 1..4, rsp_resp = 0; rsp_valid[1] never set.
- Both requesters assert in the same cycle (req0 write 0xA5 to 0x4, req1 read 0x4) -> req0 granted first, then req1; req1 reads 0xA5. Repeat -> req1 granted first.
- Req1 read of 0x10 -> no AR/AW activity, rsp_valid[1] the cycle after req_ready, rsp_resp = 2'b10, rdata = 0.
- Slave holds WREADY low 5 cycles after AWREADY -> AWVALID drops after AW handshake, WVALID held 5 cycles, single rsp_valid, correct data stored.
- ARESETN low during WRESP -> all valids/readies 0 immediately, no rsp_valid; after release, req0 write of 0x7 to 0x8 completes normally.
- Always-ready slave, back-to-back req0 writes -> rsp_valid 3 cycles after each grant, next req_ready the cycle after rsp_valid.
